// File: rtl/elevator_scheduler.sv
// Call scheduler and motion sequencer for a three-floor elevator: latches calls,
// picks targets with a direction-preserving sweep, and times travel and door intervals.
module elevator_scheduler #(
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] call,
    input  logic       sos,
    input  logic       overweight,
    output logic [2:0] pending,
    output logic [2:0] floor,
    output logic       door,
    output logic       moving,
    output logic       dir_up,
    output logic [1:0] state_dbg
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2,
        HALT      = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      pending_d, floor_d;
    logic            dir_up_d;
    logic [TW-1:0]   travel_cnt_q, travel_cnt_d;
    logic [DW-1:0]   door_cnt_q, door_cnt_d;

    logic [2:0]      req, above, below, next_floor;
    logic            travel_done, door_done;

    always_comb begin
        req         = pending | call;
        above       = floor[0] ? 3'b110 : (floor[1] ? 3'b100 : 3'b000);
        below       = floor[2] ? 3'b011 : (floor[1] ? 3'b001 : 3'b000);
        next_floor  = dir_up ? {floor[1:0], 1'b0} : {1'b0, floor[2:1]};
        travel_done = (travel_cnt_q == TW'(TRAVEL_CYCLES - 1));
        door_done   = (door_cnt_q == DW'(DOOR_CYCLES - 1));
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending;
        floor_d      = floor;
        dir_up_d     = dir_up;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;

        if (sos) begin
            // Partial travel is discarded; floor and pending stay as they are.
            state_d      = HALT;
            travel_cnt_d = '0;
            door_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pending_d = req & ~floor;
                    if (|(req & floor)) begin
                        state_d    = DOOR_OPEN;
                        door_cnt_d = '0;
                    end else if (!overweight) begin
                        // Keep sweeping the current way while work remains ahead.
                        if (|(req & above) && (dir_up || !(|(req & below)))) begin
                            state_d      = MOVING;
                            dir_up_d     = 1'b1;
                            travel_cnt_d = '0;
                        end else if (|(req & below)) begin
                            state_d      = MOVING;
                            dir_up_d     = 1'b0;
                            travel_cnt_d = '0;
                        end
                    end
                end
                MOVING: begin
                    pending_d = req;
                    if (travel_done) begin
                        floor_d      = next_floor;
                        travel_cnt_d = '0;
                        if (|(req & next_floor)) begin
                            pending_d  = req & ~next_floor;
                            state_d    = DOOR_OPEN;
                            door_cnt_d = '0;
                        end
                    end else begin
                        travel_cnt_d = travel_cnt_q + TW'(1);
                    end
                end
                DOOR_OPEN: begin
                    pending_d = pending | (call & ~floor);
                    if (|(call & floor)) begin
                        door_cnt_d = '0;
                    end else if (door_done) begin
                        // Counter stays frozen at expiry while the car is overloaded.
                        if (!overweight) begin
                            state_d    = IDLE;
                            door_cnt_d = '0;
                        end
                    end else begin
                        door_cnt_d = door_cnt_q + DW'(1);
                    end
                end
                HALT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending      <= 3'b000;
            floor        <= 3'b001;
            dir_up       <= 1'b1;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending      <= pending_d;
            floor        <= floor_d;
            dir_up       <= dir_up_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
        end
    end

    assign door      = (state_q == DOOR_OPEN);
    assign moving    = (state_q == MOVING);
    assign state_dbg = state_q;

    // The car must never be asked to shift past either end of the shaft.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == MOVING && travel_done && !sos) |-> (dir_up ? !floor[2] : !floor[0]));
    assert property (@(posedge clk) disable iff (reset) $onehot(floor));

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: hand-computed expectations checked with
// immediate assertions one cycle at a time.
module tb_elevator_scheduler;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_DOOR = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] call;
    logic       sos;
    logic       overweight;
    logic [2:0] pending;
    logic [2:0] floor;
    logic       door;
    logic       moving;
    logic       dir_up;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    elevator_scheduler #(
        .TRAVEL_CYCLES(2),
        .DOOR_CYCLES  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .sos       (sos),
        .overweight(overweight),
        .pending   (pending),
        .floor     (floor),
        .door      (door),
        .moving    (moving),
        .dir_up    (dir_up),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_car(input string tag, input logic [1:0] st, input logic [2:0] fl,
                              input logic [2:0] pe, input logic du);
        check({tag, ".state"},   {6'd0, state_dbg}, {6'd0, st});
        check({tag, ".floor"},   {5'd0, floor},     {5'd0, fl});
        check({tag, ".pending"}, {5'd0, pending},   {5'd0, pe});
        check({tag, ".dir_up"},  {7'd0, dir_up},    {7'd0, du});
        check({tag, ".door"},    {7'd0, door},      {7'd0, (st == S_DOOR)});
        check({tag, ".moving"},  {7'd0, moving},    {7'd0, (st == S_MOVE)});
    endtask

    // Drive a call pattern for one edge, then observe just after that edge.
    task automatic tick(input logic [2:0] c);
        call = c;
        @(posedge clk);
        #1;
        call = 3'b000;
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) tick(3'b000);
    endtask

    initial begin
        reset      = 1'b1;
        call       = 3'b111;
        sos        = 1'b0;
        overweight = 1'b0;

        // Reset wins over a simultaneous call pattern.
        tick(3'b111);
        expect_car("reset", S_IDLE, 3'b001, 3'b000, 1'b1);
        reset = 1'b0;

        // Floor 1 to floor 3 with a door cycle.
        tick(3'b100);
        expect_car("t2_depart", S_MOVE, 3'b001, 3'b100, 1'b1);
        tick(3'b000);
        expect_car("t2_k1", S_MOVE, 3'b001, 3'b100, 1'b1);
        tick(3'b000);
        expect_car("t2_pass2", S_MOVE, 3'b010, 3'b100, 1'b1);
        tick(3'b000);
        tick(3'b000);
        expect_car("t2_arrive", S_DOOR, 3'b100, 3'b000, 1'b1);
        idle_ticks(2);
        expect_car("t2_door_last", S_DOOR, 3'b100, 3'b000, 1'b1);
        tick(3'b000);
        expect_car("t2_idle", S_IDLE, 3'b100, 3'b000, 1'b1);

        // Back down to floor 1.
        tick(3'b001);
        expect_car("t3_down", S_MOVE, 3'b100, 3'b001, 1'b0);
        idle_ticks(4);
        expect_car("t3_at1", S_DOOR, 3'b001, 3'b000, 1'b0);
        idle_ticks(3);
        expect_car("t3_idle1", S_IDLE, 3'b001, 3'b000, 1'b0);

        // Up to floor 2; a floor-1 call arrives while the door is open.
        tick(3'b010);
        expect_car("t3_up2", S_MOVE, 3'b001, 3'b010, 1'b1);
        idle_ticks(2);
        expect_car("t3_at2", S_DOOR, 3'b010, 3'b000, 1'b1);
        tick(3'b001);
        expect_car("t3_latch_in_door", S_DOOR, 3'b010, 3'b001, 1'b1);
        idle_ticks(2);
        expect_car("t3_idle2", S_IDLE, 3'b010, 3'b001, 1'b1);

        // Sweep keeps going up first, then returns down.
        tick(3'b100);
        expect_car("t3_up_first", S_MOVE, 3'b010, 3'b101, 1'b1);
        idle_ticks(2);
        expect_car("t3_at3", S_DOOR, 3'b100, 3'b001, 1'b1);
        idle_ticks(3);
        expect_car("t3_idle3", S_IDLE, 3'b100, 3'b001, 1'b1);
        tick(3'b000);
        expect_car("t3_turn_down", S_MOVE, 3'b100, 3'b001, 1'b0);
        idle_ticks(2);
        expect_car("t3_pass2", S_MOVE, 3'b010, 3'b001, 1'b0);
        idle_ticks(2);
        expect_car("t3_back1", S_DOOR, 3'b001, 3'b000, 1'b0);
        idle_ticks(3);
        expect_car("t3_done", S_IDLE, 3'b001, 3'b000, 1'b0);

        // Overweight holds the door past expiry.
        tick(3'b010);
        expect_car("t4_depart", S_MOVE, 3'b001, 3'b010, 1'b1);
        idle_ticks(2);
        expect_car("t4_at2", S_DOOR, 3'b010, 3'b000, 1'b1);
        overweight = 1'b1;
        idle_ticks(2);
        for (int i = 0; i < 5; i++) begin
            tick(3'b000);
            expect_car($sformatf("t4_hold%0d", i), S_DOOR, 3'b010, 3'b000, 1'b1);
        end
        overweight = 1'b0;
        tick(3'b000);
        expect_car("t4_release", S_IDLE, 3'b010, 3'b000, 1'b1);

        // Emergency stop one cycle into a floor-1 to floor-3 trip.
        tick(3'b001);
        idle_ticks(2);
        expect_car("t5_at1", S_DOOR, 3'b001, 3'b000, 1'b0);
        idle_ticks(3);
        tick(3'b100);
        expect_car("t5_depart", S_MOVE, 3'b001, 3'b100, 1'b1);
        sos = 1'b1;
        tick(3'b000);
        expect_car("t5_halt", S_HALT, 3'b001, 3'b100, 1'b1);
        tick(3'b010);
        expect_car("t5_drop_call", S_HALT, 3'b001, 3'b100, 1'b1);
        sos = 1'b0;
        tick(3'b000);
        expect_car("t5_recover", S_IDLE, 3'b001, 3'b100, 1'b1);
        tick(3'b000);
        expect_car("t5_restart", S_MOVE, 3'b001, 3'b100, 1'b1);
        tick(3'b000);
        expect_car("t5_full_count", S_MOVE, 3'b001, 3'b100, 1'b1);
        tick(3'b000);
        expect_car("t5_pass2", S_MOVE, 3'b010, 3'b100, 1'b1);
        idle_ticks(2);
        expect_car("t5_at3", S_DOOR, 3'b100, 3'b000, 1'b1);
        idle_ticks(3);

        // Same-floor calls reload the door timer and never latch.
        tick(3'b001);
        idle_ticks(4);
        expect_car("t6_at1", S_DOOR, 3'b001, 3'b000, 1'b0);
        idle_ticks(3);
        expect_car("t6_idle", S_IDLE, 3'b001, 3'b000, 1'b0);
        tick(3'b001);
        expect_car("t6_same_floor", S_DOOR, 3'b001, 3'b000, 1'b0);
        tick(3'b000);
        tick(3'b001);
        expect_car("t6_reload", S_DOOR, 3'b001, 3'b000, 1'b0);
        tick(3'b100);
        expect_car("t6_latch_in_door", S_DOOR, 3'b001, 3'b100, 1'b0);
        tick(3'b000);
        expect_car("t6_door_last", S_DOOR, 3'b001, 3'b100, 1'b0);
        tick(3'b000);
        expect_car("t6_close", S_IDLE, 3'b001, 3'b100, 1'b0);
        tick(3'b000);
        expect_car("t6_serve", S_MOVE, 3'b001, 3'b100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
